// File: rtl/button_debounce_if.sv
// Button debounce interface: the button-side pin and enable coming in,
// and the conditioned level, event strobes and press count going out.
// The press counter width must match the COUNT_W of the attached
// button_debounce.
interface button_debounce_if #(
  parameter int unsigned COUNT_W = 8
);
  logic               enable;
  logic               btn_in;
  logic               btn_level;
  logic               press_pulse;
  logic               release_pulse;
  logic [COUNT_W-1:0] press_count;
  logic               long_press;

  // Consumer of the conditioned button (drives pin and enable)
  modport master (
    output enable,
    output btn_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  press_count,
    input  long_press
  );

  // The debouncer itself
  modport slave (
    input  enable,
    input  btn_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output press_count,
    output long_press
  );
endinterface

// File: rtl/button_debounce.sv
// button_debounce: conditions a raw mechanical push-button into a clean,
// clock-synchronous level plus single-cycle press/release strobes and a
// wrapping press counter.
//   - 2-flop synchronizer (free running, not gated by enable)
//   - stability counter + 4-state press FSM
//   - optional long-press detector, enabled by defining
//     BUTTON_DEBOUNCE_LONG_PRESS_EN; without it long_press is tied low
// All logic is on posedge clk with a synchronous active-high reset.
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 24,
  parameter int unsigned COUNT_W         = 8,
  parameter bit          ACTIVE_LOW      = 1'b0,
  parameter int unsigned LONG_CYCLES     = 50000000
) (
  input  logic              clk,
  input  logic              reset,
  button_debounce_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  // Last count of a stability window; acceptance happens on this count
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Raw pin level that reads as "released"; the synchronizer resets here
  // so the post-polarity value s comes out of reset as released.
  localparam logic SYNC_REST = ACTIVE_LOW;

  logic               sync1_q;
  logic               sync2_q;
  logic               s;

  state_t             state_q;
  logic [CNT_W-1:0]   stab_q;
  logic               level_q;
  logic               press_q;
  logic               release_q;
  logic [COUNT_W-1:0] count_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int unsigned    LCNT_W    = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [LCNT_W-1:0] LONG_LAST = LCNT_W'(LONG_CYCLES - 1);

  logic [LCNT_W-1:0]  lcnt_q;
  logic               fired_q;
  logic               long_q;
`endif

  // Two-flop synchronizer for the asynchronous pin
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= SYNC_REST;
      sync2_q <= SYNC_REST;
    end else begin
      sync1_q <= bus.btn_in;
      sync2_q <= sync1_q;
    end
  end

  // Polarity normalisation: s = 1 means "pressed"
  assign s = ACTIVE_LOW ? ~sync2_q : sync2_q;

  // Press FSM with stability counter, registered level/strobes/count
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      stab_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      count_q   <= '0;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
      lcnt_q    <= '0;
      fired_q   <= 1'b0;
      long_q    <= 1'b0;
`endif
    end else begin
      // Strobes last one cycle, independent of enable
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
      long_q    <= 1'b0;
`endif
      if (bus.enable) begin
        unique case (state_q)
          IDLE: begin
            if (s) begin
              state_q <= PRESS_WAIT;
              stab_q  <= '0;
            end
          end

          PRESS_WAIT: begin
            if (!s) begin
              // Glitch: drop back without any event
              state_q <= IDLE;
              stab_q  <= '0;
            end else if (stab_q == DB_LAST) begin
              state_q <= PRESSED;
              stab_q  <= '0;
              level_q <= 1'b1;
              press_q <= 1'b1;
              count_q <= count_q + COUNT_W'(1);
            end else begin
              stab_q  <= stab_q + CNT_W'(1);
            end
          end

          PRESSED: begin
            if (!s) begin
              state_q <= RELEASE_WAIT;
              stab_q  <= '0;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
              // Any excursion towards release restarts the hold timer
              lcnt_q  <= '0;
`endif
            end
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
            else if (!fired_q) begin
              if (lcnt_q == LONG_LAST) begin
                long_q  <= 1'b1;
                fired_q <= 1'b1;
              end else begin
                lcnt_q  <= lcnt_q + LCNT_W'(1);
              end
            end
`endif
          end

          RELEASE_WAIT: begin
            if (s) begin
              // Bounce: back to held without any event
              state_q <= PRESSED;
              stab_q  <= '0;
            end else if (stab_q == DB_LAST) begin
              state_q   <= IDLE;
              stab_q    <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
              fired_q   <= 1'b0;
`endif
            end else begin
              stab_q  <= stab_q + CNT_W'(1);
            end
          end

          default: begin
            state_q <= IDLE;
            stab_q  <= '0;
          end
        endcase
      end
    end
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.press_count   = count_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  assign bus.long_press    = long_q;
`else
  // No hold timer in this build; the term keeps LONG_CYCLES referenced
  assign bus.long_press    = 1'b0 & (LONG_CYCLES == 0);
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Testbench for button_debounce: two instances (active-high and
// active-low pin) driven with the same logical button, compared every
// cycle against a run-length reference model, plus directed latency,
// bounce, enable-freeze, wrap, reset and long-press scenarios.
module tb_button_debounce;

  localparam int unsigned D     = 8;
  localparam int unsigned CW    = 4;
  localparam int unsigned L     = 20;
  localparam int unsigned CNT_W = 4;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic pressed;
  logic en;

  always #5 clk = ~clk;

  button_debounce_if #(.COUNT_W(CW)) bus_a ();
  button_debounce_if #(.COUNT_W(CW)) bus_b ();

  assign bus_a.btn_in = pressed;
  assign bus_b.btn_in = ~pressed;
  assign bus_a.enable = en;
  assign bus_b.enable = en;

  button_debounce #(
    .DEBOUNCE_CYCLES(D), .CNT_W(CNT_W), .COUNT_W(CW),
    .ACTIVE_LOW(1'b0), .LONG_CYCLES(L)
  ) dut_a (.clk(clk), .reset(reset), .bus(bus_a));

  button_debounce #(
    .DEBOUNCE_CYCLES(D), .CNT_W(CNT_W), .COUNT_W(CW),
    .ACTIVE_LOW(1'b1), .LONG_CYCLES(L)
  ) dut_b (.clk(clk), .reset(reset), .bus(bus_b));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: pin pipeline plus run lengths of disagreement/hold
  logic          q1, q2;
  logic          m_level, m_pp, m_rp, m_lp;
  logic [CW-1:0] m_count;
  int            dev;
  int            held;
  bit            fired;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q1 = 1'b0; q2 = 1'b0;
    m_level = 1'b0; m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0;
    m_count = '0; dev = 0; held = 0; fired = 1'b0;
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  // A new level is accepted after D+1 consecutive enabled edges on which
  // the synchronized pin disagrees with the current level; disabled
  // edges neither extend nor break the run.
  task automatic model_step();
    logic s;
    if (reset) begin
      model_reset();
    end else begin
      s  = q2;
      q2 = q1;
      q1 = pressed;
      m_pp = 1'b0; m_rp = 1'b0; m_lp = 1'b0;
      if (en) begin
        if (LONG_EN) begin
          if (m_level && s && dev == 0) begin
            held++;
            if (held == int'(L) && !fired) begin
              m_lp  = 1'b1;
              fired = 1'b1;
            end
          end else begin
            held = 0;
          end
        end
        if (s != m_level) begin
          dev++;
          if (dev == int'(D) + 1) begin
            m_level = s;
            dev     = 0;
            held    = 0;
            if (s) begin
              m_pp    = 1'b1;
              m_count = m_count + 1'b1;
            end else begin
              m_rp  = 1'b1;
              fired = 1'b0;
            end
          end
        end else begin
          dev = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("a_level",   32'(bus_a.btn_level),     32'(m_level));
    chk("a_press",   32'(bus_a.press_pulse),   32'(m_pp));
    chk("a_release", 32'(bus_a.release_pulse), 32'(m_rp));
    chk("a_count",   32'(bus_a.press_count),   32'(m_count));
    chk("a_long",    32'(bus_a.long_press),    32'(m_lp));
    chk("b_level",   32'(bus_b.btn_level),     32'(m_level));
    chk("b_press",   32'(bus_b.press_pulse),   32'(m_pp));
    chk("b_release", 32'(bus_b.release_pulse), 32'(m_rp));
    chk("b_count",   32'(bus_b.press_count),   32'(m_count));
    chk("b_long",    32'(bus_b.long_press),    32'(m_lp));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    check_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    int lat;
    int n;
    int p;
    int len;
    bit seen;

    reset   = 1'b1;
    pressed = 1'b0;
    en      = 1'b1;
    model_reset();

    // Reset, button released
    ticks(3);
    chk("rst_level", 32'(bus_a.btn_level),   0);
    chk("rst_count", 32'(bus_a.press_count), 0);
    reset = 1'b0;
    ticks(5);

    // Clean press: strobe D+2 edges after the first sampling edge
    pressed = 1'b1;
    lat = 0;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (bus_a.press_pulse === 1'b1 && lat == 0) lat = i;
    end
    chk("press_latency", 32'(lat), 32'(D + 3));
    chk("press_level",   32'(bus_a.btn_level),   1);
    chk("press_count1",  32'(bus_a.press_count), 1);

    // Clean release
    pressed = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus_a.release_pulse === 1'b1 && lat == 0) lat = i;
    end
    chk("release_latency", 32'(lat), 32'(D + 3));
    chk("release_level",   32'(bus_a.btn_level), 0);

    // Bounce: 5 high, 2 low, 5 high, then low -> rejected
    seen = 1'b0;
    pressed = 1'b1; for (int i = 0; i < 5; i++) begin tick(); if (bus_a.press_pulse === 1'b1) seen = 1'b1; end
    pressed = 1'b0; for (int i = 0; i < 2; i++) begin tick(); if (bus_a.press_pulse === 1'b1) seen = 1'b1; end
    pressed = 1'b1; for (int i = 0; i < 5; i++) begin tick(); if (bus_a.press_pulse === 1'b1) seen = 1'b1; end
    pressed = 1'b0; for (int i = 0; i < 15; i++) begin tick(); if (bus_a.press_pulse === 1'b1) seen = 1'b1; end
    chk("bounce_pulse", 32'(seen), 0);
    chk("bounce_level", 32'(bus_a.btn_level),   0);
    chk("bounce_count", 32'(bus_a.press_count), 1);

    // Enable held low for 30 edges during the stability wait
    pressed = 1'b1;
    lat = 0;
    for (int i = 1; i <= 80; i++) begin
      en = !(i >= 5 && i <= 34);
      tick();
      if (bus_a.press_pulse === 1'b1 && lat == 0) lat = i;
    end
    en = 1'b1;
    chk("freeze_latency", 32'(lat), 32'(D + 3 + 30));
    chk("freeze_count",   32'(bus_a.press_count), 2);
    pressed = 1'b0;
    ticks(20);

    // Sixteen clean presses: count wraps past 15 back to 2
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      pressed = 1'b1;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (bus_a.press_pulse === 1'b1 && bus_a.press_count === 4'd0) seen = 1'b1;
      end
      pressed = 1'b0;
      ticks(12);
    end
    chk("wrap_seen",  32'(seen), 1);
    chk("wrap_count", 32'(bus_a.press_count), 2);

    // Reset mid-wait with the button held, then re-acceptance
    pressed = 1'b1;
    ticks(6);
    reset = 1'b1;
    tick();
    chk("midrst_level", 32'(bus_a.btn_level),   0);
    chk("midrst_count", 32'(bus_a.press_count), 0);
    reset = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (bus_a.press_pulse === 1'b1 && lat == 0) lat = i;
    end
    chk("reaccept_latency", 32'(lat), 32'(D + 3));
    p = lat;

    // Keep holding: long press (when built in) 20 edges after the strobe
    n = 0;
    lat = 0;
    for (int i = 21; i <= p + 45; i++) begin
      tick();
      if (bus_a.long_press === 1'b1) begin
        n++;
        if (lat == 0) lat = i - p;
      end
    end
    chk("long_count",   32'(n),   LONG_EN ? 1 : 0);
    chk("long_latency", 32'(lat), LONG_EN ? L : 0);
    pressed = 1'b0;
    ticks(15);

    // Randomized segments with enable drop-outs and occasional reset
    for (int seg = 0; seg < 160; seg++) begin
      len     = $urandom_range(1, 45);
      pressed = $urandom_range(0, 1) != 0;
      reset   = ($urandom_range(0, 40) == 0);
      for (int k = 0; k < len; k++) begin
        en = ($urandom_range(0, 7) != 0);
        tick();
        reset = 1'b0;
      end
    end
    en = 1'b1;
    pressed = 1'b0;
    ticks(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
